adder_operand_sequencer: RTL

Upstream feeder and result capture for the 14-bit structural adder. Collects two operands over a narrow chunked input stream with a valid/ready handshake and drives them to the adder's a/b inputs. Waits a fixed settle window, registers the adder's sum, and offers the sum downstream with a valid/ready handshake. The adder itself stays purely combinational, so inputs and outputs at board level become clean, registered transactions.

---
 rtl/adder_operand_sequencer.sv | 109 ++++++++++
 1 files changed

// File: rtl/adder_operand_sequencer.sv
// Purpose: collects two chunked operands, drives the combinational adder, captures the sum.
// Latency: result_valid rises SETTLE_CYCLES cycles after the last B chunk is accepted.
// Backpressure: in_ready only in load states; the result is held until result_ready.
module adder_operand_sequencer #(
    parameter int WIDTH         = 14,
    parameter int CHUNK         = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CHUNK-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    input  logic [WIDTH:0]   adder_sum,
    output logic [WIDTH:0]   result,
    output logic             result_valid,
    input  logic             result_ready
);

    localparam int NCH = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [1:0] LOAD_A = 2'd0;
    localparam logic [1:0] LOAD_B = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] RESULT = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] chunk_cnt;
    logic [SW-1:0] settle_cnt;
    logic          xfer;
    logic          last_chunk;
    logic          settle_done;

    assign in_ready    = (state == LOAD_A) || (state == LOAD_B);
    assign xfer        = in_valid && in_ready;
    assign last_chunk  = (chunk_cnt == CW'(NCH - 1));
    assign settle_done = (settle_cnt == SW'(SETTLE_CYCLES - 1));

    // Sequencing: chunk counting during loads, settle timing, result handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD_A;
            chunk_cnt  <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                LOAD_A, LOAD_B: begin
                    if (xfer) begin
                        if (last_chunk) begin
                            chunk_cnt <= '0;
                            state     <= (state == LOAD_A) ? LOAD_B : SETTLE;
                        end else begin
                            chunk_cnt <= chunk_cnt + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_done) begin
                        settle_cnt <= '0;
                        state      <= RESULT;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                default: begin
                    if (result_valid && result_ready) begin
                        state <= LOAD_A;
                    end
                end
            endcase
        end
    end

    // Operand registers: each accepted chunk overwrites its slice; bits past WIDTH are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adder_a <= '0;
            adder_b <= '0;
        end else if (xfer) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (chunk_cnt == CW'(i / CHUNK)) begin
                    if (state == LOAD_A) begin
                        adder_a[i] <= in_data[i % CHUNK];
                    end else begin
                        adder_b[i] <= in_data[i % CHUNK];
                    end
                end
            end
        end
    end

    // Result capture at the end of the settle window; valid drops on handshake, data stays.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result       <= '0;
            result_valid <= 1'b0;
        end else if (state == SETTLE && settle_done) begin
            result       <= adder_sum;
            result_valid <= 1'b1;
        end else if (state == RESULT && result_valid && result_ready) begin
            result_valid <= 1'b0;
        end
    end

endmodule
